// File: rtl/mldsa_axi_pkg.sv
// mldsa_axi_pkg
//   Shared definitions for the ML-DSA AXI shell.
//   Contents: mode encodings, AXI-Lite register word offsets, STATUS bit
//   positions and the control FSM state encodings.
package mldsa_axi_pkg;

  // Operation modes held in the MODE register
  localparam logic [1:0] MODE_NONE    = 2'd0;
  localparam logic [1:0] MODE_KEYGEN  = 2'd1;
  localparam logic [1:0] MODE_SIGNGEN = 2'd2;
  localparam logic [1:0] MODE_VERIFY  = 2'd3;

  // Register word offsets, which are byte address bits [3:2]
  localparam logic [1:0] REG_MODE   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  // STATUS register bit positions
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  // Control FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RECV_A = 2'd1;
  localparam state_t ST_RECV_B = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/mldsa_axil_regs.sv
// mldsa_axil_regs
//   AXI4-Lite slave that implements the register file of the ML-DSA shell.
//   Ports:
//     clk, resetn             clock and asynchronous active-high reset
//     s_axi_*                 AXI4-Lite slave. Writes and reads are single-beat,
//                             and both responses are always OKAY.
//     mode                    current MODE register value
//     start                   one-cycle pulse when CTRL bit0 is written with 1
//     busy, done, error       status inputs that are returned through STATUS
//     a_count, out_count      counters that are returned through COUNT
module mldsa_axil_regs
  import mldsa_axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [1:0]  mode,
  output logic        start,
  input  logic        busy,
  input  logic        done,
  input  logic        error,
  input  logic [15:0] a_count,
  input  logic [15:0] out_count
);

  logic        wr_fire;
  logic        rd_fire;
  logic [31:0] rd_mux;
  logic        unused_bits;

  // A write is taken only when address and data arrive together and no
  // response is still outstanding. This makes the ready a one-cycle pulse.
  assign wr_fire       = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_bresp   = 2'b00;

  assign rd_fire       = s_axi_arvalid & ~s_axi_rvalid;
  assign s_axi_arready = ~s_axi_rvalid;
  assign s_axi_rresp   = 2'b00;

  // CTRL does not store anything. Writing a 1 to bit0 produces only the
  // start pulse, so the register reads back as 0.
  assign start = wr_fire & (s_axi_awaddr[3:2] == REG_CTRL) & s_axi_wstrb[0] & s_axi_wdata[0];

  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[3:1], s_axi_wdata[31:2]};

  // MODE register and the write-response handshake
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      s_axi_bvalid <= 1'b0;
      mode         <= MODE_NONE;
    end else begin
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        if ((s_axi_awaddr[3:2] == REG_MODE) && s_axi_wstrb[0]) begin
          mode <= s_axi_wdata[1:0];
        end
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read data select
  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[3:2])
      REG_MODE:   rd_mux[1:0] = mode;
      REG_STATUS: begin
        rd_mux[STAT_BUSY]  = busy;
        rd_mux[STAT_DONE]  = done;
        rd_mux[STAT_ERROR] = error;
      end
      REG_COUNT:  rd_mux = {out_count, a_count};
      default:    rd_mux = '0;
    endcase
  end

  // Read data is registered at the handshake and held until rready
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else if (rd_fire) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_mux;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/mldsa_axi_top.sv
// mldsa_axi_top
//   AXI shell of the ML-DSA accelerator. It contains the register file, the
//   control FSM and a word-wise combine datapath.
//   Ports:
//     clk, resetn       clock and asynchronous active-high reset
//     s_axi_*           AXI4-Lite register access (MODE, CTRL, STATUS, COUNT)
//     s_axis_a_*        operand/key packet, which is buffered up to DEPTH beats
//     s_axis_b_*        message/second operand packet, which is paired with A
//                       beat by beat
//     m_axis_*          result packet with a one-entry output register
module mldsa_axi_top
  import mldsa_axi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [3:0]        s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_a_tvalid,
  input  logic              s_axis_a_tlast,
  output logic              s_axis_a_tready,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  input  logic              s_axis_b_tvalid,
  input  logic              s_axis_b_tlast,
  output logic              s_axis_b_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int AW = $clog2(DEPTH);

  state_t            state;
  logic [1:0]        mode;
  logic [1:0]        run_mode;
  logic              start;
  logic              busy;
  logic              done_q;
  logic              error_q;
  logic              b_done;
  logic [15:0]       a_count;
  logic [15:0]       out_count;
  logic [15:0]       b_idx;
  logic [AW:0]       a_stored;
  logic [DATA_W-1:0] buf_mem [DEPTH];
  logic              a_fire;
  logic              b_fire;
  logic              m_fire;
  logic              b_has_a;
  logic [DATA_W-1:0] a_operand;
  logic [DATA_W-1:0] result;

  mldsa_axil_regs u_regs (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .mode          (mode),
    .start         (start),
    .busy          (busy),
    .done          (done_q),
    .error         (error_q),
    .a_count       (a_count),
    .out_count     (out_count)
  );

  assign busy = (state == ST_RECV_A) || (state == ST_RECV_B);

  // B is accepted only while the output register is empty or is draining in
  // the same cycle. Once the last B beat is in, B stays stalled until the
  // result packet has been sent.
  assign s_axis_a_tready = (state == ST_RECV_A);
  assign s_axis_b_tready = (state == ST_RECV_B) & ~b_done & (~m_axis_tvalid | m_axis_tready);

  assign a_fire = s_axis_a_tvalid & s_axis_a_tready;
  assign b_fire = s_axis_b_tvalid & s_axis_b_tready;
  assign m_fire = m_axis_tvalid & m_axis_tready;

  // B beats that arrive after all stored A beats are used are combined with zero
  assign b_has_a   = b_idx < 16'(a_stored);
  assign a_operand = b_has_a ? buf_mem[b_idx[AW-1:0]] : '0;

  // Combine function for each mode. The mode is latched at start, so a MODE
  // write during a run has no effect on that run.
  always_comb begin
    result = '0;
    case (run_mode)
      MODE_KEYGEN:  result = a_operand;
      MODE_SIGNGEN: result = a_operand ^ s_axis_b_tdata;
      MODE_VERIFY:  result = a_operand + s_axis_b_tdata;
      default:      result = '0;
    endcase
  end

  // A-packet buffer. The MSB of a_stored marks the buffer as full, and
  // further beats are dropped.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
    end else if (a_fire && !a_stored[AW]) begin
      buf_mem[a_stored[AW-1:0]] <= s_axis_a_tdata;
    end
  end

  // Control FSM, counters, status flags and the output register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state         <= ST_IDLE;
      run_mode      <= MODE_NONE;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      b_done        <= 1'b0;
      a_count       <= '0;
      out_count     <= '0;
      b_idx         <= '0;
      a_stored      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            if (mode == MODE_NONE) begin
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state     <= ST_RECV_A;
              run_mode  <= mode;
              done_q    <= 1'b0;
              error_q   <= 1'b0;
              b_done    <= 1'b0;
              a_count   <= '0;
              out_count <= '0;
              b_idx     <= '0;
              a_stored  <= '0;
            end
          end
        end

        ST_RECV_A: begin
          if (a_fire) begin
            a_count <= a_count + 16'd1;
            if (a_stored[AW]) error_q <= 1'b1;
            else              a_stored <= a_stored + 1'b1;
            if (s_axis_a_tlast) state <= ST_RECV_B;
          end
        end

        ST_RECV_B: begin
          if (b_fire) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= result;
            m_axis_tlast  <= s_axis_b_tlast;
            b_idx         <= b_idx + 16'd1;
            if (!b_has_a) error_q <= 1'b1;
            if (s_axis_b_tlast) begin
              b_done <= 1'b1;
              if ((b_idx + 16'd1) < 16'(a_stored)) error_q <= 1'b1;
            end
          end else if (m_fire) begin
            m_axis_tvalid <= 1'b0;
          end
          if (m_fire) begin
            out_count <= out_count + 16'd1;
            if (m_axis_tlast) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mldsa_axi_top.sv
// tb_mldsa_axi_top
//   Directed bench for mldsa_axi_top. A table of packet vectors is applied
//   first. Hand-written sequences then cover the register readback, a start
//   with MODE 0, a start while busy, an output stall, A buffer overflow and
//   reset during a run.
module tb_mldsa_axi_top;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [63:0] s_axis_a_tdata;
  logic        s_axis_a_tvalid;
  logic        s_axis_a_tlast;
  logic        s_axis_a_tready;
  logic [63:0] s_axis_b_tdata;
  logic        s_axis_b_tvalid;
  logic        s_axis_b_tlast;
  logic        s_axis_b_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int vectors_applied = 0;
  int miscompares = 0;
  logic [64:0] out_q [$];

  typedef struct packed {
    logic [1:0]        mode;
    logic [2:0]        n_a;
    logic [2:0]        n_b;
    logic [3:0][63:0]  a;
    logic [3:0][63:0]  b;
    logic [3:0][63:0]  exp;
    logic [31:0]       exp_status;
    logic [31:0]       exp_count;
  } vec_t;

  vec_t vecs [5];

  mldsa_axi_top #(.DATA_W(64), .DEPTH(16)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .s_axi_awaddr    (s_axi_awaddr),
    .s_axi_awvalid   (s_axi_awvalid),
    .s_axi_awready   (s_axi_awready),
    .s_axi_wdata     (s_axi_wdata),
    .s_axi_wstrb     (s_axi_wstrb),
    .s_axi_wvalid    (s_axi_wvalid),
    .s_axi_wready    (s_axi_wready),
    .s_axi_bresp     (s_axi_bresp),
    .s_axi_bvalid    (s_axi_bvalid),
    .s_axi_bready    (s_axi_bready),
    .s_axi_araddr    (s_axi_araddr),
    .s_axi_arvalid   (s_axi_arvalid),
    .s_axi_arready   (s_axi_arready),
    .s_axi_rdata     (s_axi_rdata),
    .s_axi_rresp     (s_axi_rresp),
    .s_axi_rvalid    (s_axi_rvalid),
    .s_axi_rready    (s_axi_rready),
    .s_axis_a_tdata  (s_axis_a_tdata),
    .s_axis_a_tvalid (s_axis_a_tvalid),
    .s_axis_a_tlast  (s_axis_a_tlast),
    .s_axis_a_tready (s_axis_a_tready),
    .s_axis_b_tdata  (s_axis_b_tdata),
    .s_axis_b_tvalid (s_axis_b_tvalid),
    .s_axis_b_tlast  (s_axis_b_tlast),
    .s_axis_b_tready (s_axis_b_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready)
  );

  always #5 clk = ~clk;

  // Record every accepted output beat as {tlast, tdata}
  always @(negedge clk) begin
    if (!resetn && m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic flag_timeout(input string name);
    vectors_applied++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic axil_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_awready) begin
      flag_timeout("axil write");
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_bvalid) flag_timeout("axil bresp");
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axil_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_arready) begin
      flag_timeout("axil read addr");
      s_axi_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_rvalid) flag_timeout("axil rdata");
    else data = s_axi_rdata;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic send_a(input logic [63:0] data, input logic last);
    int n;
    @(posedge clk); #1;
    s_axis_a_tdata = data; s_axis_a_tlast = last; s_axis_a_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axis_a_tready && n < 50) begin @(negedge clk); n++; end
    if (!s_axis_a_tready) flag_timeout("stream A beat");
    else @(posedge clk);
    #1 s_axis_a_tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] data, input logic last);
    int n;
    @(posedge clk); #1;
    s_axis_b_tdata = data; s_axis_b_tlast = last; s_axis_b_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axis_b_tready && n < 50) begin @(negedge clk); n++; end
    if (!s_axis_b_tready) flag_timeout("stream B beat");
    else @(posedge clk);
    #1 s_axis_b_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st;
    int n;
    st = 32'h1;
    n = 0;
    while (st[0] && n < 100) begin axil_read(4'h8, st); n++; end
    if (st[0]) flag_timeout(name);
  endtask

  task automatic check_beats(input string name, input int n, input logic [3:0][63:0] exp);
    check_output({name, " beat count"}, 64'(out_q.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (k < out_q.size()) begin
        check_output($sformatf("%s data%0d", name, k), out_q[k][63:0], exp[k]);
        check_output($sformatf("%s last%0d", name, k), 64'(out_q[k][64]), 64'(k == n - 1));
      end
    end
  endtask

  task automatic check_reg(input string name, input logic [3:0] addr, input logic [31:0] expected);
    logic [31:0] rd;
    axil_read(addr, rd);
    check_output(name, 64'(rd), 64'(expected));
  endtask

  // Runs one table vector: program MODE, start, stream A then B, and check
  // the result packet, STATUS and COUNT
  task automatic apply_stimulus(input vec_t v, input int id);
    string name;
    name = $sformatf("vec%0d", id);
    out_q.delete();
    axil_write(4'h0, {30'd0, v.mode}, 4'hF);
    axil_write(4'h4, 32'h1, 4'hF);
    for (int k = 0; k < int'(v.n_a); k++) send_a(v.a[k], k == int'(v.n_a) - 1);
    for (int k = 0; k < int'(v.n_b); k++) send_b(v.b[k], k == int'(v.n_b) - 1);
    wait_idle({name, " idle"});
    check_beats(name, int'(v.n_b), v.exp);
    check_reg({name, " status"}, 4'h8, v.exp_status);
    check_reg({name, " count"}, 4'hC, v.exp_count);
  endtask

  initial begin
    logic [3:0][63:0] exp;
    int n;

    for (int i = 0; i < 5; i++) vecs[i] = '0;
    // SignGen, single beat
    vecs[0].mode = 2'd2; vecs[0].n_a = 3'd1; vecs[0].n_b = 3'd1;
    vecs[0].a[0] = 64'hAABBCCDD00112233; vecs[0].b[0] = 64'h1122334455667788;
    vecs[0].exp[0] = 64'hBB99FF99557755BB;
    vecs[0].exp_status = 32'h2; vecs[0].exp_count = 32'h00010001;
    // Verify, two beats, the second wraps
    vecs[1].mode = 2'd3; vecs[1].n_a = 3'd2; vecs[1].n_b = 3'd2;
    vecs[1].a[0] = 64'd1; vecs[1].a[1] = 64'hFFFFFFFFFFFFFFFF;
    vecs[1].b[0] = 64'd2; vecs[1].b[1] = 64'd1;
    vecs[1].exp[0] = 64'd3; vecs[1].exp[1] = 64'd0;
    vecs[1].exp_status = 32'h2; vecs[1].exp_count = 32'h00020002;
    // Verify, B longer than A, so the third A operand is zero
    vecs[2].mode = 2'd3; vecs[2].n_a = 3'd2; vecs[2].n_b = 3'd3;
    vecs[2].a[0] = 64'd5; vecs[2].a[1] = 64'd6;
    vecs[2].b[0] = 64'd7; vecs[2].b[1] = 64'd8; vecs[2].b[2] = 64'd9;
    vecs[2].exp[0] = 64'd12; vecs[2].exp[1] = 64'd14; vecs[2].exp[2] = 64'd9;
    vecs[2].exp_status = 32'h6; vecs[2].exp_count = 32'h00030002;
    // KeyGen passes A through
    vecs[3].mode = 2'd1; vecs[3].n_a = 3'd3; vecs[3].n_b = 3'd3;
    vecs[3].a[0] = 64'h10; vecs[3].a[1] = 64'h20; vecs[3].a[2] = 64'h30;
    vecs[3].b[0] = 64'h5; vecs[3].b[1] = 64'h6; vecs[3].b[2] = 64'h7;
    vecs[3].exp[0] = 64'h10; vecs[3].exp[1] = 64'h20; vecs[3].exp[2] = 64'h30;
    vecs[3].exp_status = 32'h2; vecs[3].exp_count = 32'h00030003;
    // SignGen, B shorter than A, which sets error
    vecs[4].mode = 2'd2; vecs[4].n_a = 3'd2; vecs[4].n_b = 3'd1;
    vecs[4].a[0] = 64'hF0F0; vecs[4].a[1] = 64'h0FF0; vecs[4].b[0] = 64'hFFFF;
    vecs[4].exp[0] = 64'h0F0F;
    vecs[4].exp_status = 32'h6; vecs[4].exp_count = 32'h00010002;

    resetn = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    s_axis_a_tdata = '0; s_axis_a_tvalid = 1'b0; s_axis_a_tlast = 1'b0;
    s_axis_b_tdata = '0; s_axis_b_tvalid = 1'b0; s_axis_b_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;

    // Reset state
    @(negedge clk);
    check_output("reset m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_output("reset a_tready", 64'(s_axis_a_tready), 64'd0);
    check_output("reset b_tready", 64'(s_axis_b_tready), 64'd0);
    check_output("reset bvalid", 64'(s_axi_bvalid), 64'd0);
    check_reg("reset status", 4'h8, 32'h0);
    check_reg("reset mode", 4'h0, 32'h0);

    // Register readback and byte strobes
    axil_write(4'h0, 32'h1, 4'hF);
    check_reg("mode readback", 4'h0, 32'h1);
    axil_write(4'h0, 32'h2, 4'b1110);
    check_reg("mode strobe masked", 4'h0, 32'h1);
    check_reg("ctrl reads zero", 4'h4, 32'h0);

    // Start with MODE 0 gives an error and does not go busy
    axil_write(4'h0, 32'h0, 4'hF);
    axil_write(4'h4, 32'h1, 4'hF);
    @(negedge clk);
    check_output("mode0 a_tready", 64'(s_axis_a_tready), 64'd0);
    check_output("mode0 b_tready", 64'(s_axis_b_tready), 64'd0);
    check_reg("mode0 status", 4'h8, 32'h6);

    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

    // A second start and a MODE change while busy must not affect the run
    out_q.delete();
    axil_write(4'h0, 32'h2, 4'hF);
    axil_write(4'h4, 32'h1, 4'hF);
    send_a(64'h1234, 1'b0);
    axil_write(4'h4, 32'h1, 4'hF);
    axil_write(4'h0, 32'h3, 4'hF);
    check_reg("busy count kept", 4'hC, 32'h00000001);
    check_reg("busy status", 4'h8, 32'h1);
    send_a(64'hFF00, 1'b1);
    send_b(64'h1, 1'b0);
    send_b(64'h2, 1'b1);
    wait_idle("busy idle");
    exp = '0; exp[0] = 64'h1235; exp[1] = 64'hFF02;
    check_beats("busy", 2, exp);
    check_reg("busy final status", 4'h8, 32'h2);

    // Output stall: tdata must hold and B must stall for 5 cycles
    out_q.delete();
    axil_write(4'h0, 32'h2, 4'hF);
    axil_write(4'h4, 32'h1, 4'hF);
    send_a(64'h11, 1'b0); send_a(64'h22, 1'b0); send_a(64'h33, 1'b1);
    m_axis_tready = 1'b0;
    send_b(64'h01, 1'b0);
    @(posedge clk); #1;
    s_axis_b_tdata = 64'h02; s_axis_b_tlast = 1'b0; s_axis_b_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output($sformatf("stall tvalid%0d", c), 64'(m_axis_tvalid), 64'd1);
      check_output($sformatf("stall tdata%0d", c), m_axis_tdata, 64'h10);
      check_output($sformatf("stall b_tready%0d", c), 64'(s_axis_b_tready), 64'd0);
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axis_b_tready && n < 50) begin @(negedge clk); n++; end
    if (!s_axis_b_tready) flag_timeout("stall release");
    else @(posedge clk);
    #1 s_axis_b_tvalid = 1'b0;
    send_b(64'h03, 1'b1);
    wait_idle("stall idle");
    exp = '0; exp[0] = 64'h10; exp[1] = 64'h20; exp[2] = 64'h30;
    check_beats("stall", 3, exp);
    check_reg("stall count", 4'hC, 32'h00030003);

    // A overflow: the 17th A beat is dropped and sets error
    out_q.delete();
    axil_write(4'h0, 32'h1, 4'hF);
    axil_write(4'h4, 32'h1, 4'hF);
    for (int k = 0; k < 17; k++) send_a(64'(k + 100), k == 16);
    send_b(64'h0, 1'b1);
    wait_idle("ovf idle");
    exp = '0; exp[0] = 64'd100;
    check_beats("ovf", 1, exp);
    check_reg("ovf status", 4'h8, 32'h6);
    check_reg("ovf count", 4'hC, 32'h00010011);

    // Reset in the middle of a run
    axil_write(4'h0, 32'h2, 4'hF);
    axil_write(4'h4, 32'h1, 4'hF);
    send_a(64'h55, 1'b0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check_output("midreset a_tready", 64'(s_axis_a_tready), 64'd0);
    @(posedge clk); #1 resetn = 1'b0;
    check_reg("midreset status", 4'h8, 32'h0);
    check_reg("midreset count", 4'hC, 32'h0);
    check_reg("midreset mode", 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mldsa_axi_top.md
Name: mldsa_axi_top

Overview:
- Top-level AXI shell of the ML-DSA accelerator.
- AXI4-Lite slave holds the mode, start and status registers.
- Two AXI-Stream inputs: A carries the operand/key packet, B the message/second operand packet. One AXI-Stream output carries the result packet.
- This block implements the control FSM and a mode-selected word-wise combine datapath. The full ML-DSA arithmetic core plugs in behind the same handshake later.

Parameters:
- DATA_W, 64, AXIS data width.
- DEPTH, 16, A-packet buffer depth in beats (power of 2).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-high reset. Asserted when 1.
- s_axi_awaddr  in  4  write address; word offset, [1:0] ignored.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response; always 00.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  4  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response; always 00.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axis_a_tdata/tvalid/tlast  in  64/1/1  stream A.
- s_axis_a_tready  out  1  stream A ready.
- s_axis_b_tdata/tvalid/tlast  in  64/1/1  stream B.
- s_axis_b_tready  out  1  stream B ready.
- m_axis_tdata/tvalid/tlast  out  64/1/1  result stream.
- m_axis_tready  in  1  result stream ready.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM in IDLE.
- AXI-Lite write path:
  - awready = wready = awvalid & wvalid & !bvalid. This is combinational and pulses for one cycle.
  - bvalid sets on the following edge and clears on bready.
  - wstrb is honoured per byte.
- AXI-Lite read path:
  - arready = !rvalid.
  - rdata and rvalid are registered one cycle after the handshake.
  - rvalid holds until rready.
- Register map:
  - 0x0 MODE[1:0], read/write. 0 = none, 1 = KeyGen, 2 = SignGen, 3 = Verify.
  - 0x4 CTRL. Writing bit0 = 1 requests start. The bit is self-clearing and reads 0.
  - 0x8 STATUS, read-only. bit0 busy, bit1 done, bit2 error.
  - 0xC COUNT, read-only. [15:0] A beats accepted, [31:16] output beats sent.
- Start handling:
  - Start is ignored when busy.
  - Start with MODE = 0 sets error and done and does not go busy.
  - A valid start clears done, error and COUNT.
- FSM states:
  - IDLE -> RECV_A on a valid start.
  - RECV_A: s_axis_a_tready = 1. Each beat is written to buf[idx] and idx increments. Beats beyond DEPTH are dropped and set error. tlast -> RECV_B.
  - RECV_B: each B beat is paired with buf[j], and j increments. If j ≥ A count, the A operand is 0 and error is set. The output word is computed per mode:
    - KeyGen: A.
    - SignGen: A ^ B.
    - Verify: A + B mod 2^64.
  - The output register is a one-entry skid. s_axis_b_tready = !m_axis_tvalid | m_axis_tready. m_axis_tlast = B tlast. If B ends with fewer beats than A, error is set.
  - After the last output beat is accepted -> DONE.
  - DONE: done = 1, busy = 0, then -> IDLE.
- Stream rules:
  - s_axis_b_tready = 0 outside RECV_B. s_axis_a_tready = 0 outside RECV_A.
  - m_axis_tdata/tlast stay stable while tvalid & !tready.
- Latency: a B beat accepted at edge N appears on m_axis at edge N+1.
- Reset asserted mid-operation aborts immediately to the reset state.

Decomposition:
- Package mldsa_axi_pkg:
  - Mode encodings.
  - Register offsets.
  - STATUS bit indices.
  - FSM state enum.
- One natural sub-module: mldsa_axil_regs (AXI-Lite handshake and register file). It exports mode, a start pulse and status inputs.

Test Plan:
- Write MODE = 2, start; A = 0xAABBCCDD00112233 (tlast); B = 0x1122334455667788 (tlast) -> m_axis 0xBB99FF99557755BB with tlast. STATUS = 0x2. COUNT = 0x00010001.
- MODE = 3, 2-beat A {1, 0xFFFFFFFFFFFFFFFF}, B {2, 1} -> outputs 3, 0 (wrap). tlast on the 2nd beat.
- m_axis_tready held 0 for 5 cycles during SignGen -> tdata stable, B stalls, no beat lost.
- Start with MODE = 0 -> STATUS = 0x6, no stream readies asserted.
- A 2 beats, B 3 beats -> third output = B (A treated as 0). STATUS error = 1, done = 1.
- Readback: write MODE = 1 then read 0x0 -> 1. CTRL reads 0. Start while busy -> ignored.
